// File: rtl/keccak_arb_pkg.sv
// Shared constants for the KeccakF400 permutation arbiter and its channel controllers.
// FSM state encoding, default permutation width and the channel control byte.
package keccak_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } arb_state_e;

    localparam int KECCAK_STATE_W = 400;

    // Marker byte the per-channel interface controllers place in their control word.
    localparam logic [7:0] CTRL_BYTE = 8'hAA;

endpackage

// File: rtl/keccak_perm_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
// Produces a one-hot grant, its binary index and a valid flag.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             valid
);

    always_comb begin
        int         idx;
        logic [PTR_W-1:0] sel;
        // NOTE: every output gets a default before the loop, so no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            sel = PTR_W'(idx);
            if (!valid && req[sel]) begin
                valid      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/keccak_perm_arbiter.sv
// Shares one KeccakF400 core between NUM_REQ requesters with round-robin arbitration.
// Optional WAIT watchdog compiled in with `define KECCAK_ARB_TIMEOUT_EN.
module keccak_perm_arbiter
    import keccak_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int STATE_W        = KECCAK_STATE_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_v_req,
    input  logic [NUM_REQ*STATE_W-1:0] i_v_req_state,
    output logic [NUM_REQ-1:0]         o_v_grant,
    output logic [NUM_REQ-1:0]         o_v_done,
    output logic [NUM_REQ-1:0]         o_v_err,
    output logic [STATE_W-1:0]         o_v_result,
    output logic                       o_busy,
    output logic                       o_start,
    output logic [STATE_W-1:0]         o_v_core_state,
    input  logic                       i_core_done,
    input  logic [STATE_W-1:0]         i_v_core_state
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("keccak_perm_arbiter: unsupported parameter set");
    end

    arb_state_e         state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] rr_grant;
    logic [PTR_W-1:0]   rr_idx;
    logic               rr_valid;
    logic [STATE_W-1:0] req_slice [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
        assign req_slice[k] = i_v_req_state[k*STATE_W +: STATE_W];
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req       (i_v_req),
        .ptr       (ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .valid     (rr_valid)
    );

    // The requester just served moves to the back of the queue.
    assign next_ptr = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    assign o_busy   = (state != ST_IDLE);

`ifdef KECCAK_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
`else
    assign o_v_err = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            gnt_idx        <= '0;
            o_v_grant      <= '0;
            o_v_done       <= '0;
            o_v_result     <= '0;
            o_start        <= 1'b0;
            o_v_core_state <= '0;
`ifdef KECCAK_ARB_TIMEOUT_EN
            o_v_err        <= '0;
            wd_cnt         <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates everywhere here; pulse outputs default low and only the case raises them.
            o_start  <= 1'b0;
            o_v_done <= '0;
`ifdef KECCAK_ARB_TIMEOUT_EN
            o_v_err  <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    if (rr_valid) begin
                        o_v_grant <= rr_grant;
                        gnt_idx   <= rr_idx;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    o_v_core_state <= req_slice[gnt_idx];
                    o_start        <= 1'b1;
                    state          <= ST_START;
                end
                ST_START: begin
`ifdef KECCAK_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_core_done) begin
                        o_v_result <= i_v_core_state;
                        o_v_done   <= o_v_grant;
                        state      <= ST_DONE;
                    end
`ifdef KECCAK_ARB_TIMEOUT_EN
                    // A done on the limit cycle takes priority over the timeout.
                    else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        o_v_err   <= o_v_grant;
                        o_v_grant <= '0;
                        ptr       <= next_ptr;
                        state     <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    o_v_grant <= '0;
                    ptr       <= next_ptr;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_perm_arbiter.sv
// Self-checking bench for keccak_perm_arbiter: directed scenarios plus randomized traffic,
// compared cycle by cycle against an operation-level reference model and a behavioural core.
module tb_keccak_perm_arbiter;

    localparam int N  = 3;
    localparam int SW = 400;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*SW-1:0] req_state;
    logic [SW-1:0]   st [N];
    logic [N-1:0]    v_grant, v_done, v_err;
    logic [SW-1:0]   v_result, v_core_state;
    logic            busy, start;
    logic            core_done = 1'b0;
    logic [SW-1:0]   core_st_in = '0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) req_state[i*SW +: SW] = st[i];
    end

    keccak_perm_arbiter #(
        .NUM_REQ        (N),
        .STATE_W        (SW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_v_req        (req),
        .i_v_req_state  (req_state),
        .o_v_grant      (v_grant),
        .o_v_done       (v_done),
        .o_v_err        (v_err),
        .o_v_result     (v_result),
        .o_busy         (busy),
        .o_start        (start),
        .o_v_core_state (v_core_state),
        .i_core_done    (core_done),
        .i_v_core_state (core_st_in)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Behavioural core controls.
    int            next_lat    = 5;
    bit            spurious_en = 1'b0;
    int            core_cnt    = 0;
    bit            hung        = 1'b0;
    logic [SW-1:0] core_in     = '0;

    // Reference model state.
    int            ptr_m     = 0;
    bit            busy_m    = 1'b0;
    bit            idle_prev = 1'b1;
    bit            cur_busy  = 1'b0;
    int            g_m       = 0;
    int            grant_cyc = -100;
    int            cc        = -1;
    int            err_cyc   = -1;
    logic [N-1:0]  err_vec   = '0;
    logic [SW-1:0] load_val  = '0;
    logic [SW-1:0] exp_core  = '0;
    logic [SW-1:0] res_m     = '0;

    function automatic logic [SW-1:0] perm_ref(input logic [SW-1:0] x);
        return {x[SW-2:0], x[SW-1]} ^ {25{16'hA5C3}};
    endfunction

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] r;
        for (int i = 0; i < SW / 16; i++) r[i*16 +: 16] = 16'($urandom);
        return r;
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: sample outputs, run the core model, run the reference model and compare.
    task automatic step();
        bit           done_now, spur_ok, in_busy, timeout_now;
        logic [N-1:0] exp_grant, exp_done, exp_err;
        @(posedge clk);
        #1;
        cyc++;
        done_now    = 1'b0;
        timeout_now = 1'b0;

        if (rst) begin
            core_cnt  = 0;
            hung      = 1'b0;
            core_done = 1'b0;
        end else begin
            spur_ok = !hung && (core_cnt == 0 || start);
            if (start) begin
                core_in  = v_core_state;
                hung     = (next_lat == 0);
                core_cnt = next_lat;
            end else if (core_cnt > 0) begin
                core_cnt--;
                done_now = (core_cnt == 0);
            end
            if (done_now) begin
                core_done  = 1'b1;
                core_st_in = perm_ref(core_in);
            end else begin
                core_done  = spurious_en && spur_ok && ($urandom % 3 == 0);
                core_st_in = rand_state();
            end
        end

        if (rst) begin
            in_busy   = 1'b0;
            busy_m    = 1'b0;
            idle_prev = 1'b1;
            ptr_m     = 0;
            res_m     = '0;
            exp_core  = '0;
            cc        = -1;
            err_cyc   = -1;
            grant_cyc = -100;
        end else begin
            in_busy = busy_m;
            if (!in_busy && idle_prev && req != '0) begin
                g_m       = pick(req, ptr_m);
                in_busy   = 1'b1;
                grant_cyc = cyc;
                cc        = -1;
                load_val  = st[g_m];
            end
            if (in_busy && done_now) cc = cyc + 1;
`ifdef KECCAK_ARB_TIMEOUT_EN
            if (in_busy && cc < 0 && !done_now && cyc == grant_cyc + 1 + TO) timeout_now = 1'b1;
`endif
        end

        exp_grant = in_busy ? (N'(1) << g_m) : '0;
        exp_done  = (in_busy && cyc == cc) ? (N'(1) << g_m) : '0;
        exp_err   = (cyc == err_cyc) ? err_vec : '0;
        if (in_busy && cyc == grant_cyc + 1) exp_core = load_val;
        if (in_busy && cyc == cc) res_m = perm_ref(load_val);

        check("grant", SW'(v_grant), SW'(exp_grant));
        check("start", SW'(start), SW'(in_busy && cyc == grant_cyc + 1));
        check("busy", SW'(busy), SW'(in_busy));
        check("done", SW'(v_done), SW'(exp_done));
        check("err", SW'(v_err), SW'(exp_err));
        check("result", v_result, res_m);
        check("core_state", v_core_state, exp_core);

        cur_busy = in_busy;
        if (in_busy && cyc == cc) begin
            busy_m = 1'b0;
            ptr_m  = (g_m + 1) % N;
        end else if (timeout_now) begin
            busy_m  = 1'b0;
            ptr_m   = (g_m + 1) % N;
            err_cyc = cyc + 1;
            err_vec = N'(1) << g_m;
        end else begin
            busy_m = in_busy;
        end
        idle_prev = !in_busy;
    endtask

    initial begin
        for (int i = 0; i < N; i++) st[i] = rand_state();
        repeat (3) step();
        rst = 1'b0;

        // Single request with a 20-cycle core.
        st[0]    = {25{16'h1234}};
        next_lat = 20;
        req      = 3'b001;
        step();
        req = '0;
        repeat (30) step();

        // Contention between requesters 0 and 1, held high.
        req = 3'b011;
        repeat (60) begin
            next_lat = $urandom_range(1, 6);
            step();
        end
        req = '0;
        repeat (10) step();

        // One-cycle request pulse still completes.
        next_lat = 7;
        req      = 3'b010;
        step();
        req = '0;
        repeat (15) step();

        // Reset five cycles after start, then a restart from pointer 0.
        next_lat = 20;
        req      = 3'b100;
        step();
        req = '0;
        repeat (6) step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        next_lat = 9;
        req      = 3'b110;
        step();
        req = '0;
        repeat (20) step();

        // Spurious core done outside WAIT.
        spurious_en = 1'b1;
        next_lat    = 10;
        req         = 3'b001;
        step();
        req = '0;
        repeat (25) step();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            next_lat = $urandom_range(1, 12);
            if ($urandom % 5 == 0) req = N'($urandom_range(0, 7));
            if (!(cur_busy && cyc == grant_cyc) && ($urandom % 6 == 0))
                st[$urandom_range(0, N - 1)] = rand_state();
            step();
        end
        req = '0;
        repeat (20) step();

`ifdef KECCAK_ARB_TIMEOUT_EN
        // Core that never finishes, then one that finishes on the limit cycle.
        spurious_en = 1'b0;
        next_lat    = 0;
        req         = 3'b001;
        step();
        req = '0;
        repeat (75) step();
        next_lat = TO;
        req      = 3'b010;
        step();
        req = '0;
        repeat (75) step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
